pipo_univ_shreg: RTL and testbench
==================================

# pipo_univ_shreg

Parametrised universal shift register: the successor to the plain parallel-in/parallel-out register. Adds shift and rotate in both directions, dual serial inputs/outputs, synchronous clear, and a shift counter that flags each completed N-bit frame. Sits in serialiser/deserialiser and data-alignment paths where a register must be loaded in parallel, then streamed out serially, or vice versa.

## Interface
- N, 4, register width in bits; legal range N ≥ 2.
- CW, $clog2(N), derived counter width; not overridden.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_mode  in  3  operation select; see Operation.
- i_parallel_in  in  N  parallel load data.
- i_serial_in_r  in  1  bit entering the MSB on shift right.
- i_serial_in_l  in  1  bit entering the LSB on shift left.
- o_parallel_out  out  N  register contents.
- o_serial_lsb  out  1  current reg[0].
- o_serial_msb  out  1  current reg[N-1].
- o_count  out  CW  shifts/rotates since the last load, clear or wrap.
- o_frame_done  out  1  one-cycle pulse after the N-th shift/rotate.

## Operation
- Core state: reg[N-1:0] and cnt[CW-1:0]. Reset value: reg = 0, cnt = 0, o_frame_done = 0. All outputs are 0 during and after reset.
- Modes, applied at the rising edge:
  - 000 HOLD: reg and cnt unchanged.
  - 001 SHR: reg ← {i_serial_in_r, reg[N-1:1]}.
  - 010 SHL: reg ← {reg[N-2:0], i_serial_in_l}.
  - 011 ROR: reg ← {reg[0], reg[N-1:1]}.
  - 100 ROL: reg ← {reg[N-2:0], reg[N-1]}.
  - 101 LOAD: reg ← i_parallel_in; cnt ← 0.
  - 110 CLEAR: reg ← 0; cnt ← 0.
  - 111 reserved: behaves exactly as HOLD.
- Counter: each SHR, SHL, ROR or ROL increments cnt.
  - If cnt == N-1 at that edge, cnt wraps to 0 and o_frame_done is 1 for the following cycle.
  - In every other cycle, o_frame_done is 0.
  - Direction changes mid-frame do not reset cnt.
- LOAD and CLEAR never raise o_frame_done, and they discard any partial count.
- o_serial_lsb and o_serial_msb are combinational taps of reg, with no extra register.
- Asynchronous reset asserted mid-frame immediately zeroes reg, cnt and all outputs. The first edge after release executes i_mode normally.

## Timing
- Default build: o_parallel_out = reg. A LOAD at edge k is visible on o_parallel_out after edge k, giving one cycle of latency from i_parallel_in.
- o_count and o_frame_done are registered and update on the same edge as reg.
- Serial taps have zero added latency relative to reg in all builds.
- There is no handshake. i_mode is sampled every edge and must be held stable around the edge.

## Configuration
- PIPO_UNIV_SHREG_OUTREG_EN defined:
  - Adds an output holding stage, o_parallel_out ← reg, updated every edge and reset to 0.
  - A LOAD therefore appears on o_parallel_out two edges after i_parallel_in is sampled.
  - o_frame_done and o_count are delayed by the same one stage, so they stay aligned with o_parallel_out.
- PIPO_UNIV_SHREG_OUTREG_EN undefined: no extra stage. Latency is as given in Timing.

## Structure
- Shared package pipo_univ_shreg_pkg holds:
  - typedef enum logic [2:0] shreg_mode_e, with values HOLD, SHR, SHL, ROR, ROL, LOAD, CLEAR, RSVD matching the encodings above.
  - Mode-width constant SHREG_MODE_W = 3.
- One sub-module, shreg_frame_cnt, holds the frame counter.
  - Parameter: N.
  - Inputs: i_clk, i_rst, i_step, i_clear.
  - Outputs: o_count, o_wrap.
- The datapath mux and register live in the top module.

## Test plan
- Reset, then LOAD 4'b1011 at edge 1 → o_parallel_out = 1011 after edge 1, o_serial_lsb = 1, o_serial_msb = 1, o_count = 0.
- LOAD 1011, then 4× SHR with i_serial_in_r = 0 → 0101, 0010, 0001, 0000; o_count = 1, 2, 3, 0; o_frame_done = 1 only after the 4th shift.
- LOAD 1000, then ROL ×2, ROR ×2 → 0001, 0010, 0001, 1000; o_frame_done pulses after the 4th op (mixed directions count).
- LOAD 0000, then SHL ×2 with i_serial_in_l = 1, then mode 111 for 3 cycles, then CLEAR → 0011 held for 3 cycles with o_count = 2; after CLEAR, reg = 0000, o_count = 0, no frame pulse.
- LOAD 1111, SHR ×2, assert i_rst mid-cycle → outputs go to 0 before the next edge; after release, LOAD 0110 → 0110 with o_count = 0.
- With PIPO_UNIV_SHREG_OUTREG_EN defined, repeat scenario 2 → every value and the o_frame_done pulse appear exactly one cycle later, with serial taps unchanged in timing.

Source files
------------

// File: rtl/pipo_univ_shreg_pkg.sv
// Shared types and constants for the universal shift register and its frame counter.
package pipo_univ_shreg_pkg;

    localparam int SHREG_MODE_W = 3;

    typedef enum logic [SHREG_MODE_W-1:0] {
        HOLD  = 3'b000,
        SHR   = 3'b001,
        SHL   = 3'b010,
        ROR   = 3'b011,
        ROL   = 3'b100,
        LOAD  = 3'b101,
        CLEAR = 3'b110,
        RSVD  = 3'b111
    } shreg_mode_e;

endpackage

// File: rtl/shreg_frame_cnt.sv
// Counts shift/rotate steps modulo N and pulses o_wrap for one cycle after the N-th step.
module shreg_frame_cnt #(
    parameter int N = 4,
    localparam int CW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_step,
    input  logic          i_clear,
    output logic [CW-1:0] o_count,
    output logic          o_wrap
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_count <= '0;
            o_wrap  <= 1'b0;
        end else begin
            o_wrap <= 1'b0;
            if (i_clear) begin
                o_count <= '0;
            end else if (i_step) begin
                if (o_count == CW'(N - 1)) begin
                    o_count <= '0;
                    o_wrap  <= 1'b1;
                end else begin
                    o_count <= o_count + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pipo_univ_shreg.sv
// Universal shift register: parallel load, shift/rotate both ways, clear, frame counter.
// Define PIPO_UNIV_SHREG_OUTREG_EN to add one output holding stage on parallel/count/frame outputs.
module pipo_univ_shreg
    import pipo_univ_shreg_pkg::*;
#(
    parameter int N = 4,
    localparam int CW = $clog2(N)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [SHREG_MODE_W-1:0] i_mode,
    input  logic [N-1:0]            i_parallel_in,
    input  logic                    i_serial_in_r,
    input  logic                    i_serial_in_l,
    output logic [N-1:0]            o_parallel_out,
    output logic                    o_serial_lsb,
    output logic                    o_serial_msb,
    output logic [CW-1:0]           o_count,
    output logic                    o_frame_done
);

    shreg_mode_e   mode;
    logic [N-1:0]  data_q;
    logic [N-1:0]  data_nxt;
    logic          step;
    logic          clear;
    logic [CW-1:0] cnt;
    logic          wrap;

    assign mode = shreg_mode_e'(i_mode);

    // NOTE: defaults assigned first so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        data_nxt = data_q;
        step     = 1'b0;
        clear    = 1'b0;
        case (mode)
            SHR: begin
                data_nxt = {i_serial_in_r, data_q[N-1:1]};
                step     = 1'b1;
            end
            SHL: begin
                data_nxt = {data_q[N-2:0], i_serial_in_l};
                step     = 1'b1;
            end
            ROR: begin
                data_nxt = {data_q[0], data_q[N-1:1]};
                step     = 1'b1;
            end
            ROL: begin
                data_nxt = {data_q[N-2:0], data_q[N-1]};
                step     = 1'b1;
            end
            LOAD: begin
                data_nxt = i_parallel_in;
                clear    = 1'b1;
            end
            CLEAR: begin
                data_nxt = '0;
                clear    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_nxt;
        end
    end

    shreg_frame_cnt #(.N(N)) u_frame_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_step  (step),
        .i_clear (clear),
        .o_count (cnt),
        .o_wrap  (wrap)
    );

    // Serial taps always come straight from the core register.
    assign o_serial_lsb = data_q[0];
    assign o_serial_msb = data_q[N-1];

`ifdef PIPO_UNIV_SHREG_OUTREG_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_parallel_out <= '0;
            o_count        <= '0;
            o_frame_done   <= 1'b0;
        end else begin
            o_parallel_out <= data_q;
            o_count        <= cnt;
            o_frame_done   <= wrap;
        end
    end
`else
    assign o_parallel_out = data_q;
    assign o_count        = cnt;
    assign o_frame_done   = wrap;
`endif

endmodule

// File: tb/tb_pipo_univ_shreg.sv
// Scoreboard bench for pipo_univ_shreg: an independent model pushes expected outputs per edge.
module tb_pipo_univ_shreg;
    import pipo_univ_shreg_pkg::*;

    localparam int N  = 4;
    localparam int CW = $clog2(N);

    typedef struct {
        logic [N-1:0]  par;
        logic          lsb;
        logic          msb;
        logic [CW-1:0] cnt;
        logic          fd;
        string         tag;
    } exp_t;

    logic                    i_clk = 1'b0;
    logic                    i_rst = 1'b1;
    logic [SHREG_MODE_W-1:0] i_mode = '0;
    logic [N-1:0]            i_parallel_in = '0;
    logic                    i_serial_in_r = 1'b0;
    logic                    i_serial_in_l = 1'b0;
    logic [N-1:0]            o_parallel_out;
    logic                    o_serial_lsb;
    logic                    o_serial_msb;
    logic [CW-1:0]           o_count;
    logic                    o_frame_done;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];

    logic [N-1:0] m_reg = '0;
    int           m_cnt = 0;
    logic         m_fd  = 1'b0;

    pipo_univ_shreg #(.N(N)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_mode         (i_mode),
        .i_parallel_in  (i_parallel_in),
        .i_serial_in_r  (i_serial_in_r),
        .i_serial_in_l  (i_serial_in_l),
        .o_parallel_out (o_parallel_out),
        .o_serial_lsb   (o_serial_lsb),
        .o_serial_msb   (o_serial_msb),
        .o_count        (o_count),
        .o_frame_done   (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_reset();
        m_reg = '0;
        m_cnt = 0;
        m_fd  = 1'b0;
    endtask

    // Drive one operation, push the expected post-edge outputs, then pop and compare.
    task automatic do_op(input shreg_mode_e m, input logic [N-1:0] pin,
                         input logic sr, input logic sl, input string tag);
        logic [N-1:0] nr;
        logic         stp;
        logic         clr;
        exp_t         e;
        exp_t         got;
        @(negedge i_clk);
        i_mode        = m;
        i_parallel_in = pin;
        i_serial_in_r = sr;
        i_serial_in_l = sl;
        nr  = m_reg;
        stp = 1'b0;
        clr = 1'b0;
        case (m)
            SHR:   begin nr = {sr, m_reg[N-1:1]};        stp = 1'b1; end
            SHL:   begin nr = {m_reg[N-2:0], sl};        stp = 1'b1; end
            ROR:   begin nr = {m_reg[0], m_reg[N-1:1]};  stp = 1'b1; end
            ROL:   begin nr = {m_reg[N-2:0], m_reg[N-1]}; stp = 1'b1; end
            LOAD:  begin nr = pin;                       clr = 1'b1; end
            CLEAR: begin nr = '0;                        clr = 1'b1; end
            default: ;
        endcase
`ifdef PIPO_UNIV_SHREG_OUTREG_EN
        e.par = m_reg;
        e.cnt = CW'(m_cnt);
        e.fd  = m_fd;
`endif
        if (clr) begin
            m_cnt = 0;
            m_fd  = 1'b0;
        end else if (stp) begin
            m_fd  = (m_cnt == N - 1);
            m_cnt = (m_cnt + 1) % N;
        end else begin
            m_fd = 1'b0;
        end
        m_reg = nr;
`ifndef PIPO_UNIV_SHREG_OUTREG_EN
        e.par = m_reg;
        e.cnt = CW'(m_cnt);
        e.fd  = m_fd;
`endif
        e.lsb = m_reg[0];
        e.msb = m_reg[N-1];
        e.tag = tag;
        sb.push_back(e);

        @(posedge i_clk);
        #1;
        got = sb.pop_front();
        checks++;
        if (o_parallel_out !== got.par) begin
            errors++;
            $display("FAIL %s par: got %b expected %b", got.tag, o_parallel_out, got.par);
        end
        checks++;
        if (o_serial_lsb !== got.lsb) begin
            errors++;
            $display("FAIL %s lsb: got %b expected %b", got.tag, o_serial_lsb, got.lsb);
        end
        checks++;
        if (o_serial_msb !== got.msb) begin
            errors++;
            $display("FAIL %s msb: got %b expected %b", got.tag, o_serial_msb, got.msb);
        end
        checks++;
        if (o_count !== got.cnt) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", got.tag, o_count, got.cnt);
        end
        checks++;
        if (o_frame_done !== got.fd) begin
            errors++;
            $display("FAIL %s frame_done: got %b expected %b", got.tag, o_frame_done, got.fd);
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({o_parallel_out, o_serial_lsb, o_serial_msb, o_count, o_frame_done} !== '0) begin
            errors++;
            $display("FAIL %s zero: got par=%b lsb=%b msb=%b cnt=%0d fd=%b expected all 0",
                     tag, o_parallel_out, o_serial_lsb, o_serial_msb, o_count, o_frame_done);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check_zero("reset_hold");
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
        do_op(LOAD, 4'b1011, 1'b0, 1'b0, "load_1011");
    endtask

    task automatic test_shr_frame();
        do_op(LOAD, 4'b1011, 1'b0, 1'b0, "shr_load");
        for (int i = 0; i < 4; i++) do_op(SHR, '0, 1'b0, 1'b0, "shr");
        do_op(HOLD, '0, 1'b0, 1'b0, "shr_after");
    endtask

    task automatic test_rotate_mixed();
        do_op(LOAD, 4'b1000, 1'b0, 1'b0, "rot_load");
        do_op(ROL, '0, 1'b0, 1'b0, "rol1");
        do_op(ROL, '0, 1'b0, 1'b0, "rol2");
        do_op(ROR, '0, 1'b0, 1'b0, "ror1");
        do_op(ROR, '0, 1'b0, 1'b0, "ror2");
        do_op(HOLD, '0, 1'b0, 1'b0, "rot_after");
    endtask

    task automatic test_shl_hold_clear();
        do_op(LOAD, 4'b0000, 1'b0, 1'b0, "shl_load");
        do_op(SHL, '0, 1'b0, 1'b1, "shl1");
        do_op(SHL, '0, 1'b0, 1'b1, "shl2");
        for (int i = 0; i < 3; i++) do_op(RSVD, 4'b1111, 1'b1, 1'b1, "rsvd");
        do_op(CLEAR, 4'b1111, 1'b1, 1'b1, "clear");
        do_op(HOLD, '0, 1'b0, 1'b0, "clear_after");
    endtask

    task automatic test_async_reset();
        do_op(LOAD, 4'b1111, 1'b0, 1'b0, "ar_load");
        do_op(SHR, '0, 1'b0, 1'b0, "ar_shr1");
        do_op(SHR, '0, 1'b0, 1'b0, "ar_shr2");
        @(negedge i_clk);
        i_mode = HOLD;
        #2 i_rst = 1'b1;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        do_op(LOAD, 4'b0110, 1'b0, 1'b0, "ar_reload");
    endtask

    task automatic test_back_to_back();
        do_op(LOAD, 4'b0101, 1'b0, 1'b0, "b2b_load");
        do_op(SHL, '0, 1'b0, 1'b1, "b2b_shl");
        do_op(ROR, '0, 1'b0, 1'b0, "b2b_ror");
        do_op(LOAD, 4'b1001, 1'b0, 1'b0, "b2b_reload");
        for (int i = 0; i < 9; i++) begin
            do_op(shreg_mode_e'(3'($urandom_range(1, 4))), '0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "b2b_rand");
        end
        do_op(HOLD, '0, 1'b0, 1'b0, "b2b_after");
    endtask

    initial begin
        test_reset();
        test_shr_frame();
        test_rotate_mixed();
        test_shl_hold_clear();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
